// File: rtl/frame_window.sv
// Streaming window multiplier: each sample is scaled by an external ROM coefficient picked by its
// position in the frame. The result is rounded half-up and saturated.
module frame_window #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int FRAME_LEN = 512,
    parameter int SYMMETRIC = 1,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              frame_sync,
    output logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_first,
    output logic              out_last
);

    localparam int PW = DATA_W + COEF_W + 1;
    localparam logic [PW:0] RND = (PW + 1)'(1) << (COEF_W - 1);
    localparam logic signed [PW:0] MAXV = {{(PW - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PW:0] MINV = ~MAXV;

    logic              adv;
    logic              accept;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] eff_idx;
    logic [ADDR_W-1:0] idx_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    logic              s1_valid, s1_first, s1_last;
    logic [DATA_W-1:0] s1_data;
    logic              s2_valid, s2_first, s2_last, s2_coef_ok;
    logic [DATA_W-1:0] s2_data;
    logic [COEF_W-1:0] s2_coef;
    logic              s3_valid, s3_first, s3_last;
    logic [DATA_W-1:0] s3_data;
    logic [COEF_W-1:0] s3_coef;

    logic signed [PW-1:0] prod;
    logic signed [PW:0]   rnd;
    logic signed [PW:0]   shf;
    logic [DATA_W-1:0]    res;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    assign eff_idx = frame_sync ? '0 : idx;

    always_comb begin
        idx_nxt = idx + ADDR_W'(1);
        if (frame_sync || idx == ADDR_W'(FRAME_LEN - 1)) begin
            idx_nxt = '0;
        end
    end

    // The symmetric ROM stores the first half only; the second half mirrors back onto it.
    always_comb begin
        addr_nxt = eff_idx;
        if (SYMMETRIC != 0 && eff_idx >= ADDR_W'(FRAME_LEN / 2)) begin
            addr_nxt = ADDR_W'(FRAME_LEN - 1) - eff_idx;
        end
    end

    assign prod = $signed({{(COEF_W + 1){s3_data[DATA_W-1]}}, s3_data})
                * $signed({{DATA_W{1'b0}}, 1'b0, s3_coef});
    assign rnd  = {prod[PW-1], prod} + RND;
    assign shf  = rnd >>> COEF_W;

    always_comb begin
        if (shf > MAXV) begin
            res = MAXV[DATA_W-1:0];
        end else if (shf < MINV) begin
            res = MINV[DATA_W-1:0];
        end else begin
            res = shf[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            coef_addr  <= '0;
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            s2_coef_ok <= 1'b0;
            s3_valid   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_first  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            // coef_in is only valid on the first edge after a sample enters S2; keep it during a stall.
            if (s2_valid && !s2_coef_ok) begin
                s2_coef_ok <= 1'b1;
            end
            if (adv) begin
                s1_valid   <= accept;
                s2_valid   <= s1_valid;
                s2_coef_ok <= 1'b0;
                s3_valid   <= s2_valid;
                out_valid  <= s3_valid;
                out_data   <= res;
                out_first  <= s3_first;
                out_last   <= s3_last;
                if (accept) begin
                    idx       <= idx_nxt;
                    coef_addr <= addr_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s2_valid && !s2_coef_ok) begin
            s2_coef <= coef_in;
        end
        if (adv) begin
            if (accept) begin
                s1_data  <= in_data;
                s1_first <= (eff_idx == '0);
                s1_last  <= (eff_idx == ADDR_W'(FRAME_LEN - 1));
            end
            s2_data  <= s1_data;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s3_data  <= s2_data;
            s3_coef  <= s2_coef_ok ? s2_coef : coef_in;
            s3_first <= s2_first;
            s3_last  <= s2_last;
        end
    end

endmodule

// File: tb/tb_frame_window.sv
// Scoreboard bench for frame_window: a driver pushes modelled results on every accept and a
// monitor pops and compares on every output beat.
module tb_frame_window;

    localparam int DW  = 16;
    localparam int CW  = 16;
    localparam int FL  = 8;
    localparam int SYM = 1;
    localparam int AW  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          frame_sync = 1'b0;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_first;
    logic          out_last;

    frame_window #(
        .DATA_W   (DW),
        .COEF_W   (CW),
        .FRAME_LEN(FL),
        .SYMMETRIC(SYM),
        .ADDR_W   (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .frame_sync(frame_sync),
        .coef_addr (coef_addr),
        .coef_in   (coef_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Window coefficients by ROM address; the ROM model has one cycle of read latency.
    int unsigned rom_m [FL];
    always @(posedge clk) coef_in <= CW'(rom_m[int'(coef_addr) % FL]);

    typedef struct {
        int data;
        bit first;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   m_idx = 0;
    int   total = 0;
    int   passed = 0;
    bit   pend = 1'b0;
    int   pend_addr = 0;

    function automatic int mirror(int i);
        return (SYM != 0 && i >= FL / 2) ? FL - 1 - i : i;
    endfunction

    function automatic int win_out(int d, int i);
        longint p;
        longint r;
        p = longint'(d) * longint'(rom_m[mirror(i)]);
        r = (p + 64'sd32768) >>> CW;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic check(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic cycle(bit v, int d, bit fs, bit ordy);
        @(negedge clk);
        if (pend) check("coef_addr", int'(coef_addr), pend_addr);
        pend       = 1'b0;
        in_valid   = v;
        in_data    = DW'(d);
        frame_sync = fs;
        out_ready  = ordy;
        #1;
        if (v && in_ready && !rst) begin
            int   i;
            int   ds;
            exp_t e;
            ds = int'($signed(in_data));
            i = fs ? 0 : m_idx;
            m_idx = fs ? 0 : ((m_idx == FL - 1) ? 0 : m_idx + 1);
            e.data  = win_out(ds, i);
            e.first = (i == 0);
            e.last  = (i == FL - 1);
            exp_q.push_back(e);
            pend      = 1'b1;
            pend_addr = mirror(i);
        end
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        rst        = 1'b1;
        in_valid   = 1'b0;
        frame_sync = 1'b0;
        exp_q.delete();
        m_idx = 0;
        pend  = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_first", out_first, 0);
        check("rst_out_last", out_last, 0);
        check("rst_coef_addr", int'(coef_addr), 0);
        repeat (n) @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", in_ready, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) cycle(1'b0, 0, 1'b0, 1'b1);
        check("drain_left", exp_q.size(), 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", int'($signed(out_data)), e.data);
                    check("out_first", out_first, e.first);
                    check("out_last", out_last, e.last);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] snap_data;
        logic [AW-1:0] snap_addr;

        for (int i = 0; i < FL; i++) rom_m[i] = 32768;
        do_reset(2);

        // Single sample latency
        cycle(1'b1, 1000, 1'b0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            cycle(1'b0, 0, 1'b0, 1'b1);
            check("latency_valid", out_valid, (j == 3) ? 1 : 0);
        end

        // Half-gain continuous stream
        for (int k = 0; k < 12; k++) cycle(1'b1, 1000, 1'b0, 1'b1);
        drain();

        // Mirrored address pattern across a frame boundary
        rom_m[0] = 40000; rom_m[1] = 30000; rom_m[2] = 20000; rom_m[3] = 10000;
        do_reset(1);
        for (int k = 0; k < 10; k++) cycle(1'b1, int'($urandom), 1'b0, 1'b1);
        drain();

        // Extreme values and rounding
        rom_m[0] = 65535; rom_m[1] = 65535; rom_m[2] = 32768;
        do_reset(1);
        cycle(1'b1, -32768, 1'b0, 1'b1);
        cycle(1'b1, 32767, 1'b0, 1'b1);
        cycle(1'b1, 3, 1'b0, 1'b1);
        drain();

        // Backpressure with a full pipeline
        for (int k = 0; k < 6; k++) cycle(1'b1, int'($urandom), 1'b0, 1'b1);
        snap_data = '0;
        snap_addr = '0;
        for (int j = 0; j < 5; j++) begin
            cycle(1'b1, int'($urandom), 1'b0, 1'b0);
            check("stall_in_ready", in_ready, 0);
            if (j == 0) begin
                check("stall_out_valid", out_valid, 1);
                snap_data = out_data;
                snap_addr = coef_addr;
            end else begin
                check("stall_out_valid_hold", out_valid, 1);
                check("stall_out_data_hold", int'(out_data), int'(snap_data));
                check("stall_coef_addr_hold", int'(coef_addr), int'(snap_addr));
            end
        end
        for (int k = 0; k < 4; k++) cycle(1'b1, int'($urandom), 1'b0, 1'b1);
        drain();

        // frame_sync at index 5, then reset mid-frame
        do_reset(1);
        for (int k = 0; k < 5; k++) cycle(1'b1, int'($urandom), 1'b0, 1'b1);
        cycle(1'b1, int'($urandom), 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b1, int'($urandom), 1'b0, 1'b1);
        do_reset(1);
        for (int k = 0; k < 4; k++) cycle(1'b1, int'($urandom), 1'b0, 1'b1);
        drain();

        // Randomised traffic
        for (int i = 0; i < FL / 2; i++) rom_m[i] = $urandom_range(0, 65535);
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 9) < 7, int'($urandom), $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) < 7);
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
